lbdr_route_unit: RTL and testbench
==================================

// Module: lbdr_route_unit
// PURPOSE
//  Parametrised LBDR route unit for one router input port. Minimal routing is driven by
//  8 routing bits (2 per output) and 4 connectivity bits (1 per output).
//  Per-packet state machine: HEADER computes the route, TAIL releases it.
//  Route/connectivity/address registers can be rewritten at run time through a cfg port
//  while the unit is idle.
//  Sits between the input FIFO and the switch allocator.
// PARAMETERS
//  XW       2  width of X coordinate field (dst/cur addr bits [XW-1:0])
//  YW       2  width of Y coordinate field (addr bits [XW+YW-1:XW])
//  RXY_DEF  8'd60  Rxy value taken on reset when rst_cfg_sel=0
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous active-high reset
//  rst_cfg_sel  in   1      at reset: 1 = load *_rst inputs, 0 = load defaults (RXY_DEF, Cx=4'hF, cur=0)
//  Rxy_rst      in   8      reset routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//  Cx_rst       in   4      reset connectivity {Cs,Cw,Ce,Cn}
//  cur_addr_rst in   XW+YW  reset router address
//  empty        in   1      input FIFO empty; flit fields ignored when 1
//  flit_id      in   3      `HEADER / `PAYLOAD / `TAIL (shared parameters include)
//  dst_addr     in   XW+YW  destination address, sampled on HEADER only
//  cfg_we       in   1      config write strobe
//  cfg_sel      in   2      0=Rxy, 1=Cx (wdata[3:0]), 2=cur_addr, 3=deroute (see CONFIGURATION)
//  cfg_wdata    in   8      config write data, LSB-aligned
//  Nport/Eport/Wport/Sport/Lport out 1 each  registered output-port request
//  busy         out  1      1 while a packet route is held (state ROUTED)
//  route_err    out  1      one-cycle pulse: no legal port / protocol error
// BEHAVIOUR
//  Reset (rst=1): all ports, busy and route_err = 0; state=IDLE; config regs loaded per rst_cfg_sel.
//  Comparators: N1=y_dst<y_cur, S1=y_cur<y_dst, E1=x_cur<x_dst, W1=x_dst<x_cur (unsigned, YW/XW wide).
//  Minimal mask is the standard LBDR equations:
//   N=(N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn, E=(E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res)&Ce,
//   W=(W1&~N1&~S1 | W1&N1&Rwn | W1&S1&Rws)&Cw, S=(S1&~E1&~W1 | S1&E1&Rse | S1&W1&Rsw)&Cs,
//   L=~N1&~E1&~W1&~S1.
//  FSM IDLE:
//   - ~empty & HEADER: ports <= mask next cycle; state -> ROUTED.
//   - If mask==0: ports stay 0, route_err=1 for 1 cycle, state stays IDLE.
//   - PAYLOAD/TAIL in IDLE: ignored, route_err pulse.
//  FSM ROUTED:
//   - Ports held constant on PAYLOAD and while empty=1.
//   - ~empty & TAIL: ports <= 0, busy <= 0, state -> IDLE (1-cycle latency).
//   - ~empty & HEADER (missing tail): re-route with the new dst, route_err pulse; stays ROUTED if mask!=0.
//  Latency: exactly 1 clk from flit sampled to ports updated.
//  cfg writes: applied only when state=IDLE and the same cycle is not a routed HEADER.
//   Otherwise dropped silently. A write and a HEADER in the same IDLE cycle: the HEADER uses the old values.
//  Reset mid-packet: immediate return to IDLE; ports cleared next edge.
//  Exactly one of N/E/W/S/L is asserted, except when both Rxy bits of a quadrant allow two ports (multi-port mask legal).
// CONFIGURATION
//  LBDR_DEROUTE_EN defined:
//   - 8-bit deroute reg, cfg_sel=3; 2 bits per primary direction {S,W,E,N}; value 0=N 1=E 2=W 3=S.
//   - Reset value 8'h00.
//   - When the minimal mask==0 and L==0: primary dir = first of N1,E1,W1,S1 in N,E,W,S order.
//   - The deroute port for that primary dir is asserted if its Cx bit is 1; else route_err.
//  Not defined: cfg_sel=3 writes ignored; mask==0 always gives route_err (no deroute logic synthesised).
// TESTING
//  T1 reset rst_cfg_sel=1, Rxy=8'h3C, Cx=F, cur=4'h5; HEADER dst=4'h5 -> Lport=1 next cycle, busy=1.
//  T2 cur=5, HEADER dst=4'hF (x=3,y=3; E1&S1, Res=1) -> Eport=1 only; PAYLOADx3 hold; TAIL -> all 0, busy=0.
//  T3 Cx=4'hD (Ce=0), HEADER dst=4'h7 -> all ports 0, route_err one cycle, busy=0.
//  T4 in ROUTED: cfg_we sel=0 wdata=8'hFF -> Rxy unchanged after TAIL; same write in IDLE -> takes effect for next HEADER.
//  T5 LBDR_DEROUTE_EN, Cx=4'hD, deroute=8'b00_00_11_00 (E->S), HEADER dst=4'h7 -> Sport=1, no route_err.
//  T6 rst asserted mid-packet with Wport=1 -> Wport=0, busy=0 next edge; next PAYLOAD gives route_err.

Source files
------------

// File: rtl/lbdr_route_unit.sv
// lbdr_route_unit
// LBDR (Logic-Based Distributed Routing) route unit for one router input port.
// It sits between the input FIFO and the switch allocator. A HEADER flit
// computes the output-port request, which is then held until the TAIL flit.
// The Rxy, Cx and cur_addr registers can be rewritten through the cfg port
// while the unit is idle.
//
// Optional feature: define LBDR_DEROUTE_EN to add a deroute register
// (cfg_sel=3). With it, a packet whose minimal mask is empty is sent to a
// configured fallback port instead of being rejected.
//
// Flit type codes come from the shared `HEADER/`PAYLOAD/`TAIL macros. If no
// shared include has defined them, local defaults are provided below.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_route_unit #(
  parameter int         XW      = 2,
  parameter int         YW      = 2,
  parameter logic [7:0] RXY_DEF = 8'd60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_cfg_sel,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic [XW+YW-1:0]   cur_addr_rst,
  input  logic               empty,
  input  logic [2:0]         flit_id,
  input  logic [XW+YW-1:0]   dst_addr,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [7:0]         cfg_wdata,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               busy,
  output logic               route_err
);

  localparam int AW = XW + YW;

  typedef enum logic {IDLE, ROUTED} state_t;

  state_t          state;
  logic [7:0]      rxy_q;
  logic [3:0]      cx_q;
  logic [AW-1:0]   cur_q;
`ifdef LBDR_DEROUTE_EN
  logic [7:0]      der_q;
`endif

  // Port vectors use the bit order {L,S,W,E,N}
  logic [4:0]      mask_p0;
  logic [4:0]      route_p0;
  logic [4:0]      port_p1;
  logic            n1_p0, e1_p0, w1_p0, s1_p0;
  logic            hdr_p0, pay_p0, tail_p0;

  // Standard LBDR minimal-routing equations.
  // Rxy bit order is {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}.
  // Cx bit order is {Cs,Cw,Ce,Cn}.
  function automatic logic [4:0] lbdr_mask(
    input logic       n1,
    input logic       e1,
    input logic       w1,
    input logic       s1,
    input logic [7:0] rxy,
    input logic [3:0] cx
  );
    logic n, e, w, s, l;
    n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
    e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
    w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
    s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
    l = ~n1 & ~e1 & ~w1 & ~s1;
    return {l, s, w, e, n};
  endfunction

`ifdef LBDR_DEROUTE_EN
  // The fallback port is looked up from the primary direction,
  // which is the first of N,E,W,S that the destination lies in.
  // The fallback is used only if that port is connected.
  function automatic logic [4:0] deroute_pick(
    input logic       n1,
    input logic       e1,
    input logic       w1,
    input logic [7:0] der,
    input logic [3:0] cx
  );
    logic [1:0] prim;
    logic [1:0] tgt;
    logic [4:0] pick;
    prim = n1 ? 2'd0 : (e1 ? 2'd1 : (w1 ? 2'd2 : 2'd3));
    tgt  = der[{prim, 1'b0} +: 2];
    pick = 5'b0;
    pick[tgt] = cx[tgt];
    return pick;
  endfunction
`endif

  // Stage p0: decode the flit type and compute the route from the current config
  always_comb begin
    hdr_p0  = ~empty && (flit_id == `HEADER);
    pay_p0  = ~empty && (flit_id == `PAYLOAD);
    tail_p0 = ~empty && (flit_id == `TAIL);
    n1_p0   = dst_addr[AW-1:XW] < cur_q[AW-1:XW];
    s1_p0   = cur_q[AW-1:XW]    < dst_addr[AW-1:XW];
    e1_p0   = cur_q[XW-1:0]     < dst_addr[XW-1:0];
    w1_p0   = dst_addr[XW-1:0]  < cur_q[XW-1:0];
    mask_p0  = lbdr_mask(n1_p0, e1_p0, w1_p0, s1_p0, rxy_q, cx_q);
    route_p0 = mask_p0;
`ifdef LBDR_DEROUTE_EN
    if (mask_p0 == 5'b0)
      route_p0 = deroute_pick(n1_p0, e1_p0, w1_p0, der_q, cx_q);
`endif
  end

  // Stage p1: packet FSM, registered port request and config register writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      port_p1   <= 5'b0;
      busy      <= 1'b0;
      route_err <= 1'b0;
      rxy_q     <= rst_cfg_sel ? Rxy_rst      : RXY_DEF;
      cx_q      <= rst_cfg_sel ? Cx_rst       : 4'hF;
      cur_q     <= rst_cfg_sel ? cur_addr_rst : '0;
`ifdef LBDR_DEROUTE_EN
      der_q     <= 8'h00;
`endif
    end else begin
      route_err <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_p0) begin
            if (route_p0 != 5'b0) begin
              port_p1 <= route_p0;
              busy    <= 1'b1;
              state   <= ROUTED;
            end else begin
              route_err <= 1'b1;
            end
          end else if (pay_p0 || tail_p0) begin
            route_err <= 1'b1;
          end
        end
        ROUTED: begin
          if (tail_p0) begin
            port_p1 <= 5'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (hdr_p0) begin
            // A HEADER arrived without a TAIL: route the new packet
            // and flag the protocol error
            route_err <= 1'b1;
            port_p1   <= route_p0;
            if (route_p0 == 5'b0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Config writes land only while idle and not during a HEADER that routes
      if (cfg_we && (state == IDLE) && !(hdr_p0 && (route_p0 != 5'b0))) begin
        case (cfg_sel)
          2'd0:    rxy_q <= cfg_wdata;
          2'd1:    cx_q  <= cfg_wdata[3:0];
          2'd2:    cur_q <= cfg_wdata[AW-1:0];
`ifdef LBDR_DEROUTE_EN
          default: der_q <= cfg_wdata;
`else
          default: ;
`endif
        endcase
      end
    end
  end

  assign Nport = port_p1[0];
  assign Eport = port_p1[1];
  assign Wport = port_p1[2];
  assign Sport = port_p1[3];
  assign Lport = port_p1[4];

endmodule

// File: tb/tb_lbdr_route_unit.sv
// Testbench for lbdr_route_unit (XW=YW=2, RXY_DEF=60).
// Directed scenarios use literal expectations; a random phase follows.
// A quadrant-based reference model is checked on every cycle.
// Macro LBDR_DEROUTE_EN selects the deroute variant of the model.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_lbdr_route_unit;

  logic       clk = 1'b0;
  logic       rst, rst_cfg_sel, empty, cfg_we;
  logic [7:0] Rxy_rst, cfg_wdata;
  logic [3:0] Cx_rst, cur_addr_rst, dst_addr;
  logic [2:0] flit_id;
  logic [1:0] cfg_sel;
  logic       Nport, Eport, Wport, Sport, Lport, busy, route_err;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model state
  logic [7:0] m_rxy, m_der;
  logic [3:0] m_cx, m_cur;
  bit         m_routed, m_busy, m_err;
  logic [4:0] m_ports;   // {L,S,W,E,N}

  lbdr_route_unit #(.XW(2), .YW(2), .RXY_DEF(8'd60)) dut (
    .clk(clk), .rst(rst), .rst_cfg_sel(rst_cfg_sel), .Rxy_rst(Rxy_rst),
    .Cx_rst(Cx_rst), .cur_addr_rst(cur_addr_rst), .empty(empty),
    .flit_id(flit_id), .dst_addr(dst_addr), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .Nport(Nport), .Eport(Eport),
    .Wport(Wport), .Sport(Sport), .Lport(Lport), .busy(busy),
    .route_err(route_err)
  );

  always #5 clk = ~clk;

  // Direction indices are 0=N, 1=E, 2=W, 3=S, 4=L.
  // The model works from the quadrant the destination lies in.
  function automatic logic [4:0] model_route(input logic [3:0] dst, input logic [3:0] cur,
                                             input logic [7:0] rxy, input logic [3:0] cx,
                                             input logic [7:0] der);
    int xd, yd, xc, yc, v, h, vbit, hbit, prim, tgt;
    logic [4:0] r;
    xd = int'(dst[1:0]); yd = int'(dst[3:2]);
    xc = int'(cur[1:0]); yc = int'(cur[3:2]);
    r = 5'b0;
    if (xd == xc && yd == yc) return 5'b10000;
    v = (yd < yc) ? 0 : ((yd > yc) ? 3 : -1);
    h = (xd > xc) ? 1 : ((xd < xc) ? 2 : -1);
    if (h < 0) r[v] = cx[v];
    else if (v < 0) r[h] = cx[h];
    else begin
      // Turn permission: vertical move toward h uses Rne/Rnw/Rse/Rsw,
      // horizontal move toward v uses Ren/Res/Rwn/Rws
      vbit = (v == 0) ? ((h == 1) ? 0 : 1) : ((h == 1) ? 6 : 7);
      hbit = (h == 1) ? ((v == 0) ? 2 : 3) : ((v == 0) ? 4 : 5);
      if (rxy[vbit] && cx[v]) r[v] = 1'b1;
      if (rxy[hbit] && cx[h]) r[h] = 1'b1;
    end
`ifdef LBDR_DEROUTE_EN
    if (r == 5'b0) begin
      prim = (v == 0) ? 0 : ((h >= 0) ? h : 3);
      tgt  = int'((der >> (2 * prim)) & 8'h3);
      if (cx[tgt]) r[tgt] = 1'b1;
    end
`else
    prim = der[0]; tgt = prim;
`endif
    return r;
  endfunction

  task automatic model_step();
    bit hdr, pay, tl, was_idle;
    logic [4:0] r;
    if (rst) begin
      m_rxy = rst_cfg_sel ? Rxy_rst : 8'd60;
      m_cx  = rst_cfg_sel ? Cx_rst : 4'hF;
      m_cur = rst_cfg_sel ? cur_addr_rst : 4'h0;
      m_der = 8'h00;
      m_routed = 0; m_ports = 5'b0; m_busy = 0; m_err = 0;
      return;
    end
    hdr = !empty && flit_id == `HEADER;
    pay = !empty && flit_id == `PAYLOAD;
    tl  = !empty && flit_id == `TAIL;
    r = model_route(dst_addr, m_cur, m_rxy, m_cx, m_der);
    was_idle = !m_routed;
    m_err = 0;
    if (was_idle) begin
      if (hdr) begin
        if (r != 0) begin m_ports = r; m_routed = 1; end
        else m_err = 1;
      end else if (pay || tl) m_err = 1;
    end else begin
      if (tl) begin m_ports = 0; m_routed = 0; end
      else if (hdr) begin
        m_err = 1; m_ports = r;
        if (r == 0) m_routed = 0;
      end
    end
    m_busy = m_routed;
    if (cfg_we && was_idle && !(hdr && r != 0)) begin
      case (cfg_sel)
        2'd0: m_rxy = cfg_wdata;
        2'd1: m_cx  = cfg_wdata[3:0];
        2'd2: m_cur = cfg_wdata[3:0];
        default: begin
`ifdef LBDR_DEROUTE_EN
          m_der = cfg_wdata;
`endif
        end
      endcase
    end
  endtask

  // Advance the model on the same edge as the DUT
  always @(posedge clk) model_step();

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({Lport, Sport, Wport, Eport, Nport, busy, route_err} !== {m_ports, m_busy, m_err}) begin
        miscompares++;
        $display("FAIL model t=%0t dut {L,S,W,E,N,busy,err}=%b model=%b", $time,
                 {Lport, Sport, Wport, Eport, Nport, busy, route_err}, {m_ports, m_busy, m_err});
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit e, input logic [2:0] id, input logic [3:0] d,
                      input bit we, input logic [1:0] s, input logic [7:0] wd);
    empty = e; flit_id = id; dst_addr = d;
    cfg_we = we; cfg_sel = s; cfg_wdata = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] ports();
    return {Lport, Sport, Wport, Eport, Nport};
  endfunction

  initial begin
    rst = 1; rst_cfg_sel = 1; Rxy_rst = 8'h3C; Cx_rst = 4'hF; cur_addr_rst = 4'h5;
    empty = 1; flit_id = 0; dst_addr = 0; cfg_we = 0; cfg_sel = 0; cfg_wdata = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    rst = 0;
    chk_en = 1;
    lit("reset_state", {1'b0, ports(), busy, route_err}, 8'h00);

    // T1: local delivery
    step(0, `HEADER, 4'h5, 0, 0, 0);
    lit("t1_ports", ports(), 5'b10000);
    lit("t1_busy", busy, 1);
    step(0, `TAIL, 4'h5, 0, 0, 0);
    lit("t1_tail", {1'b0, ports(), busy}, 0);

    // T2: SE quadrant, Res=1 and Rse=0 -> E only, held across payload
    step(0, `HEADER, 4'hF, 0, 0, 0);
    lit("t2_hdr", ports(), 5'b00010);
    for (int i = 0; i < 3; i++) begin
      step(0, `PAYLOAD, 4'h0, 0, 0, 0);
      lit("t2_hold", ports(), 5'b00010);
    end
    step(0, `TAIL, 4'h0, 0, 0, 0);
    lit("t2_tail", {1'b0, ports(), busy}, 0);

    // T3: east link down -> no legal port
    step(1, 0, 0, 1, 2'd1, 8'h0D);
    step(0, `HEADER, 4'h7, 0, 0, 0);
    lit("t3_ports", ports(), 0);
    lit("t3_err", route_err, 1);
    lit("t3_busy", busy, 0);
    step(1, 0, 0, 0, 0, 0);
    lit("t3_err_pulse", route_err, 0);

`ifdef LBDR_DEROUTE_EN
    // T5: deroute E -> S
    step(1, 0, 0, 1, 2'd3, 8'h0C);
    step(0, `HEADER, 4'h7, 0, 0, 0);
    lit("t5_ports", ports(), 5'b01000);
    lit("t5_err", route_err, 0);
    step(0, `TAIL, 4'h7, 0, 0, 0);
`endif

    // T4: config write dropped while routed, taken while idle
    step(1, 0, 0, 1, 2'd1, 8'h0F);
    step(0, `HEADER, 4'hF, 0, 0, 0);
    step(0, `PAYLOAD, 4'hF, 1, 2'd0, 8'hFF);
    step(0, `TAIL, 4'hF, 0, 0, 0);
    step(0, `HEADER, 4'hF, 0, 0, 0);
    lit("t4_dropped", ports(), 5'b00010);
    step(0, `TAIL, 4'hF, 0, 0, 0);
    step(1, 0, 0, 1, 2'd0, 8'hFF);
    step(0, `HEADER, 4'hF, 0, 0, 0);
    lit("t4_applied", ports(), 5'b01010);
    step(0, `TAIL, 4'hF, 0, 0, 0);

    // T6: reset mid-packet
    step(0, `HEADER, 4'h4, 0, 0, 0);
    lit("t6_west", ports(), 5'b00100);
    rst = 1;
    step(1, 0, 0, 0, 0, 0);
    rst = 0;
    lit("t6_reset", {1'b0, ports(), busy}, 0);
    step(0, `PAYLOAD, 4'h4, 0, 0, 0);
    lit("t6_err", route_err, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int k;
      rst = ($urandom % 50) == 0;
      rst_cfg_sel = $urandom % 2;
      Rxy_rst = 8'($urandom);
      Cx_rst = 4'($urandom);
      cur_addr_rst = 4'($urandom);
      k = $urandom % 8;
      step(($urandom % 4) == 0,
           (k < 3) ? `HEADER : (k < 5) ? `PAYLOAD : (k < 7) ? `TAIL : 3'b000,
           4'($urandom), ($urandom % 5) == 0, 2'($urandom), 8'($urandom));
    end
    rst = 0;
    step(1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
